ifetch_queue: RTL and testbench
===============================

// Module: ifetch_queue
// PURPOSE
//  Parametrised successor to ifetch: fetches instruction words from a synchronous
//  single-cycle-latency instruction memory into a DEPTH-entry prefetch queue.
//  Presents {inst, pc} to decode under a valid/ready handshake and redirects on branch.
//  A branch kills in-flight fetches and flushes the queue.
//  Sits between the instruction memory (DP_mem32x64k port) and the decode stage.
// PARAMETERS
//  ADDR      16  instruction address width in words; PC wraps modulo 2^ADDR
//  WORD      32  instruction word width
//  DEPTH     4   queue entries; power of two, >= 2
//  RESET_PC  0   first fetch address after reset
// PORTS
//  clk         in   1     clock, rising edge
//  rst         in   1     asynchronous, active-low reset
//  mem_addr_o  out  ADDR  instruction memory address
//  mem_en_o    out  1     fetch request this cycle; data returns on mem_data_i next cycle
//  mem_data_i  in   WORD  memory read data, valid one cycle after mem_en_o
//  branch_i    in   1     redirect request, single-cycle pulse
//  baddr_i     in   ADDR  branch target, sampled when branch_i=1
//  v_o         out  1     queue head valid
//  ready_i     in   1     decode accepts head; pop = v_o & ready_i
//  inst_o      out  WORD  head instruction
//  pc_o        out  ADDR  address of head instruction
//  count_o     out  clog2(DEPTH)+1  queue occupancy (debug/perf)
// BEHAVIOUR
//  Reset (rst=0, async): fetch_pc=RESET_PC, queue empty, no fetch in flight.
//   Outputs during reset: v_o=0, inst_o=0, pc_o=0, count_o=0, mem_en_o=0.
//  Issue rule: mem_en_o=1 iff rst=1 and (count + inflight - pop) < DEPTH, or branch_i=1.
//   On issue: mem_addr_o=fetch_pc; fetch_pc <= fetch_pc+1.
//   Issue also sets inflight=1 and inflight_pc=issued address.
//   When mem_en_o=0: mem_addr_o holds fetch_pc.
//  Return: the cycle after an issue, mem_data_i is pushed with inflight_pc,
//   unless the fetch was killed by a branch.
//  Latency: a pushed entry is visible on v_o/inst_o/pc_o the cycle after the push.
//   Memory issue to v_o is 2 cycles; no bypass.
//  Steady state: with ready_i=1 held, one instruction per cycle after the initial 2-cycle fill.
//  Backpressure: ready_i=0 freezes the head. Fetches continue until count + inflight = DEPTH.
//   Never overflow; a returning in-flight word always has a free slot.
//  Branch (branch_i=1 in cycle T):
//   - queue flushed at end of T; count=0 at T+1
//   - any fetch returning in T+1 that was issued before T is discarded
//     (epoch bit toggles on branch; tag mismatch drops the word)
//   - mem_addr_o=baddr_i, mem_en_o=1 in T (combinational redirect); fetch_pc <= baddr_i+1
//   - target instruction appears on v_o at T+2 with pc_o=baddr_i
//  Simultaneous pop and branch: the pop completes (decode consumed the head); flush still applies.
//  Branch while queue is full or ready_i=0: flush and redirect regardless.
//  Back-to-back branches: the last one wins; each kills the prior redirect fetch.
//  Wrap: fetch_pc = 2^ADDR-1 is followed by 0; no error.
//  Empty queue: v_o=0; inst_o and pc_o read 0.
//  Reset asserted mid-operation: the queue and in-flight fetch are discarded immediately.
//   The first fetch after release is to RESET_PC.
// STRUCTURE
//  Shared include params.vh: ADDR, WORD defaults, RESET_PC, NOP encoding.
//  Sub-module fetch_fifo: synchronous FIFO, DEPTH x (ADDR+WORD).
//   Ports: push, pop, flush; outputs count, head; async active-low reset.
//   Pointers wrap modulo DEPTH.
//  Top-level logic: fetch_pc register, inflight flag/pc/epoch, issue credit logic.
// TESTING  (DEPTH=4, RESET_PC=0, memory word[a] = 0xA000_0000 | a)
//  1. Release reset, hold ready_i=1 -> mem_en_o=1 at cycle 0 addr 0;
//     v_o=1 from cycle 2; pc_o=0,1,2,... one per cycle; inst_o=0xA0000000+pc.
//  2. ready_i=0 from reset -> count_o saturates at 4, mem_en_o drops to 0, head stays pc 0.
//     Raise ready_i -> pcs 0..7 are delivered in order with no gaps or duplicates.
//  3. Steady streaming, branch_i=1 with baddr_i=0x1234 at cycle T -> in T mem_addr_o=0x1234;
//     v_o=0 at T+1; v_o=1 at T+2 with pc_o=0x1234; then 0x1235, 0x1236, ...
//  4. branch_i at T (baddr 0x100) and T+1 (baddr 0x200) -> no 0x100 entry is delivered;
//     first pc_o=0x200 at T+3.
//  5. baddr_i=0xFFFE with ready_i=1 -> delivered pcs are 0xFFFE, 0xFFFF, 0x0000, 0x0001.
//  6. Assert rst low while queue is full -> v_o=0 and count_o=0 immediately, without a clock edge;
//     after release the first pc_o=0.

Source files
------------

// File: rtl/ifetch_queue_pkg.sv
// Shared defaults and helper types for the instruction fetch queue.
// The top and its FIFO import this package.
package ifetch_queue_pkg;

  localparam int ADDR_DEF  = 16;
  localparam int WORD_DEF  = 32;
  localparam int DEPTH_DEF = 4;

  // What happens to the word arriving on the memory data bus this cycle
  typedef enum logic [1:0] {
    RET_NONE,
    RET_PUSH,
    RET_DROP
  } ret_e;

  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifetch_queue_fetch_fifo.sv
// Small prefetch FIFO holding {pc, inst} pairs; flush empties it in one cycle.
// Head reads as zero whenever the FIFO is empty.
module ifetch_queue_fetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = ADDR_DEF + WORD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DW-1:0]            din,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DW-1:0]            head
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          pop_ok;
  logic          push_ok;

  always_comb begin
    pop_ok  = pop && (count_reg != '0);
    push_ok = push && ((count_reg != (PW+1)'(DEPTH)) || pop_ok);
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push_ok && !flush && (wr_ptr_reg == PW'(gi)))
        mem[gi] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(push_ok);
      rd_ptr_reg <= rd_ptr_reg + PW'(pop_ok);
      count_reg  <= count_reg + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end

  assign count = count_reg;
  assign head  = (count_reg != '0) ? mem[rd_ptr_reg] : '0;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch: issues fetches to a 1-cycle memory, queues returned words,
// and hands {inst, pc} to decode; a branch flushes and redirects.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int              ADDR     = ADDR_DEF,
  parameter int              WORD     = WORD_DEF,
  parameter int              DEPTH    = DEPTH_DEF,
  parameter logic [ADDR-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [ADDR-1:0]        mem_addr_o,
  output logic                   mem_en_o,
  input  logic [WORD-1:0]        mem_data_i,
  input  logic                   branch_i,
  input  logic [ADDR-1:0]        baddr_i,
  output logic                   v_o,
  input  logic                   ready_i,
  output logic [WORD-1:0]        inst_o,
  output logic [ADDR-1:0]        pc_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int CNT_W = count_width(DEPTH);

  logic [ADDR-1:0]  fetch_pc_reg;
  logic [ADDR-1:0]  inflight_pc_reg;
  logic             inflight_reg;
  logic             inflight_epoch_reg;
  logic             epoch_reg;
  logic             pop;
  logic             push;
  logic             credit_ok;
  logic [CNT_W:0]   credit;
  ret_e             ret_kind;
  logic [ADDR+WORD-1:0] head;

  // A new fetch may issue only if its word will find a free slot next cycle,
  // counting the word already returning now and the pop happening now.
  always_comb begin
    pop        = v_o && ready_i;
    credit     = {1'b0, count_o} + (CNT_W+1)'(inflight_reg) - (CNT_W+1)'(pop);
    credit_ok  = credit < (CNT_W+1)'(DEPTH);
    mem_en_o   = rst && (credit_ok || branch_i);
    mem_addr_o = (rst && branch_i) ? baddr_i : fetch_pc_reg;
    ret_kind   = RET_NONE;
    if (inflight_reg)
      ret_kind = (branch_i || (inflight_epoch_reg != epoch_reg)) ? RET_DROP : RET_PUSH;
    push = (ret_kind == RET_PUSH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg       <= RESET_PC;
      inflight_pc_reg    <= '0;
      inflight_reg       <= 1'b0;
      inflight_epoch_reg <= 1'b0;
      epoch_reg          <= 1'b0;
    end else begin
      inflight_reg <= mem_en_o;
      if (mem_en_o) begin
        inflight_pc_reg <= mem_addr_o;
        fetch_pc_reg    <= mem_addr_o + ADDR'(1);
      end
      // Redirect fetch carries the post-branch epoch so older returns never match
      if (branch_i)
        epoch_reg <= ~epoch_reg;
      inflight_epoch_reg <= branch_i ? ~epoch_reg : epoch_reg;
    end
  end

  ifetch_queue_fetch_fifo #(
    .DEPTH (DEPTH),
    .DW    (ADDR + WORD)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (branch_i),
    .din   ({inflight_pc_reg, mem_data_i}),
    .count (count_o),
    .head  (head)
  );

  assign v_o    = (count_o != '0);
  assign pc_o   = head[ADDR+WORD-1:WORD];
  assign inst_o = head[WORD-1:0];

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: memory model, scoreboard of expected pcs,
// immediate assertions at each comparison.
module tb_ifetch_queue;

  localparam int ADDR  = 16;
  localparam int WORD  = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [ADDR-1:0]  mem_addr_o;
  logic             mem_en_o;
  logic [WORD-1:0]  mem_data_i = '0;
  logic             branch_i = 1'b0;
  logic [ADDR-1:0]  baddr_i = '0;
  logic             v_o;
  logic             ready_i = 1'b0;
  logic [WORD-1:0]  inst_o;
  logic [ADDR-1:0]  pc_o;
  logic [$clog2(DEPTH):0] count_o;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  ifetch_queue #(
    .ADDR     (ADDR),
    .WORD     (WORD),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_addr_o (mem_addr_o),
    .mem_en_o   (mem_en_o),
    .mem_data_i (mem_data_i),
    .branch_i   (branch_i),
    .baddr_i    (baddr_i),
    .v_o        (v_o),
    .ready_i    (ready_i),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .count_o    (count_o)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word[a] = 0xA000_0000 | a
  always @(posedge clk)
    if (mem_en_o) mem_data_i <= 32'hA000_0000 | {16'h0000, mem_addr_o};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every handshake against the scoreboard
  task automatic mon();
    logic [15:0] e;
    if (v_o && ready_i) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pop: observed pc=%0h expected no transfer", pc_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        $display("xfer pc=%04h inst=%08h exp_pc=%04h", pc_o, inst_o, e);
        chk("pop_pc", {16'h0000, pc_o}, {16'h0000, e});
        chk("pop_inst", inst_o, 32'hA000_0000 | {16'h0000, e});
      end
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic fin();
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    to_neg();
    fin();
  endtask

  task automatic drain(input string tag, input int limit, output int n);
    n = 0;
    while (sb.size() != 0 && n < limit) begin
      step();
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    branch_i = 1'b0;
    ready_i = 1'b0;
    baddr_i = '0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic push_range(input logic [15:0] first, input int n);
    logic [15:0] p;
    p = first;
    for (int i = 0; i < n; i++) begin
      sb.push_back(p);
      p = p + 16'd1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset values
    #2;
    chk("rst_v", v_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_mem_en", mem_en_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_pc", pc_o, 0);

    // 1: streaming from reset
    do_reset();
    ready_i = 1'b1;
    push_range(16'h0000, 8);
    to_neg(); chk("t1_en_c0", mem_en_o, 1); chk("t1_addr_c0", mem_addr_o, 0); chk("t1_v_c0", v_o, 0); fin();
    to_neg(); chk("t1_v_c1", v_o, 0); fin();
    to_neg(); chk("t1_v_c2", v_o, 1); chk("t1_pc_c2", pc_o, 0); fin();
    drain("t1_drain", 20, n);
    ready_i = 1'b0;

    // 2: backpressure from reset, then release
    do_reset();
    repeat (8) step();
    to_neg();
    chk("t2_count_full", count_o, 4);
    chk("t2_en_full", mem_en_o, 0);
    chk("t2_v_full", v_o, 1);
    chk("t2_head_pc", pc_o, 0);
    chk("t2_head_inst", inst_o, 32'hA000_0000);
    fin();
    push_range(16'h0000, 8);
    ready_i = 1'b1;
    drain("t2_drain", 20, n);
    chk("t2_gapless_cycles", n, 8);
    ready_i = 1'b0;

    // 3: branch during streaming
    do_reset();
    ready_i = 1'b1;
    push_range(16'h0000, 5);
    repeat (6) step();
    branch_i = 1'b1;
    baddr_i = 16'h1234;
    to_neg(); chk("t3_redirect_addr", mem_addr_o, 16'h1234); chk("t3_redirect_en", mem_en_o, 1); fin();
    branch_i = 1'b0;
    push_range(16'h1234, 4);
    to_neg(); chk("t3_v_t1", v_o, 0); chk("t3_count_t1", count_o, 0); fin();
    to_neg(); chk("t3_v_t2", v_o, 1); chk("t3_pc_t2", pc_o, 16'h1234); fin();
    drain("t3_drain", 20, n);
    ready_i = 1'b0;

    // 4: back-to-back branches, last one wins
    do_reset();
    ready_i = 1'b1;
    push_range(16'h0000, 5);
    repeat (6) step();
    branch_i = 1'b1;
    baddr_i = 16'h0100;
    step();
    baddr_i = 16'h0200;
    to_neg(); chk("t4_addr_b2", mem_addr_o, 16'h0200); fin();
    branch_i = 1'b0;
    push_range(16'h0200, 4);
    to_neg(); chk("t4_v_t2", v_o, 0); fin();
    to_neg(); chk("t4_v_t3", v_o, 1); chk("t4_pc_t3", pc_o, 16'h0200); fin();
    drain("t4_drain", 20, n);
    ready_i = 1'b0;

    // 5: address wrap
    do_reset();
    ready_i = 1'b1;
    branch_i = 1'b1;
    baddr_i = 16'hFFFE;
    to_neg(); chk("t5_addr", mem_addr_o, 16'hFFFE); fin();
    branch_i = 1'b0;
    sb.push_back(16'hFFFE);
    sb.push_back(16'hFFFF);
    sb.push_back(16'h0000);
    sb.push_back(16'h0001);
    drain("t5_drain", 20, n);
    ready_i = 1'b0;

    // 6: asynchronous reset while full
    do_reset();
    repeat (8) step();
    to_neg(); chk("t6_count_full", count_o, 4); fin();
    rst = 1'b0;
    #1;
    chk("t6_async_v", v_o, 0);
    chk("t6_async_count", count_o, 0);
    chk("t6_async_en", mem_en_o, 0);
    chk("t6_async_pc", pc_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    ready_i = 1'b1;
    push_range(16'h0000, 4);
    to_neg(); chk("t6_first_addr", mem_addr_o, 0); chk("t6_first_en", mem_en_o, 1); fin();
    drain("t6_drain", 20, n);
    ready_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
